// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM state, word width and address helpers for conv and conv_maxpool
package conv_pkg;
    localparam int WORD_W = 32;
    typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RD3, WR, DONE} pool_state_t;
    localparam logic [15:0] TAP0_OFF = 16'd0;
    localparam logic [15:0] TAP1_OFF = 16'd1;
    function automatic int conv_addr_w(input int dsize);
        return $clog2(dsize) + 1;
    endfunction
    // Offsets of the four window taps: 0, 1, pitch, pitch+1
    function automatic logic [15:0] tap_offset(input logic [1:0] k, input logic [7:0] pitch);
        return (k[1] ? {8'd0, pitch} : 16'd0) + (k[0] ? TAP1_OFF : TAP0_OFF);
    endfunction
endpackage

// File: rtl/conv_maxpool_pool_mem.sv
// pool_mem: pooled result memory, one synchronous write port and one combinational read port
module pool_mem
    import conv_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/conv_maxpool.sv
// conv_maxpool: 2x2 stride-2 signed max pooling of conv results into a host-readable memory
// CONV_POOL_RELU_EN clamps negative pooled values to zero before they are written
module conv_maxpool
    import conv_pkg::*;
#(
    parameter int DSIZE = 1024,
    parameter int ODEPTH = DSIZE / 4,
    parameter int ADDR_W = conv_addr_w(DSIZE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_width,
    input  logic [7:0]        in_height,
    input  logic [7:0]        row_pitch,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WORD_W-1:0] rd_data,
    input  logic [ADDR_W-1:0] po_addr,
    output logic [WORD_W-1:0] po_data,
    output logic              done,
    output logic              overflow
);
    localparam int MAW = ODEPTH > 1 ? $clog2(ODEPTH) : 1;
    pool_state_t state;
    logic [7:0] i, j, out_w, out_h;
    logic [WORD_W-1:0] max_q, wr_val, mem_rd;
    logic [15:0] base, idx;
    logic [1:0] tap;
    logic reading, idx_ok, take, last_col, last_row, empty;
    assign out_w = in_width >> 1;
    assign out_h = in_height >> 1;
    assign empty = out_w == 8'd0 || out_h == 8'd0;
    assign base = 16'({i, 1'b0}) * 16'(row_pitch) + 16'({j, 1'b0});
    assign idx = 16'(i) * 16'(out_w) + 16'(j);
    assign idx_ok = 32'(idx) < ODEPTH;
    assign tap = state == RD1 ? 2'd1 : state == RD2 ? 2'd2 : state == RD3 ? 2'd3 : 2'd0;
    assign reading = state == RD0 || state == RD1 || state == RD2 || state == RD3;
    assign rd_addr = reading ? ADDR_W'(base + tap_offset(tap, row_pitch)) : '0;
    // Strict greater-than keeps the earlier tap on ties
    assign take = $signed(rd_data) > $signed(max_q);
    assign last_col = j == out_w - 8'd1;
    assign last_row = i == out_h - 8'd1;
`ifdef CONV_POOL_RELU_EN
    assign wr_val = max_q[WORD_W-1] ? '0 : max_q;
`else
    assign wr_val = max_q;
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            i <= '0;
            j <= '0;
            max_q <= '0;
            done <= 1'b0;
            overflow <= 1'b0;
        end else
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= empty ? DONE : RD0;
                        i <= '0;
                        j <= '0;
                        done <= 1'b0;
                        overflow <= 1'b0;
                    end else if (state == DONE)
                        done <= 1'b1;
                end
                RD0: begin
                    max_q <= rd_data;
                    state <= RD1;
                end
                RD1, RD2, RD3: begin
                    if (take) max_q <= rd_data;
                    state <= state == RD1 ? RD2 : state == RD2 ? RD3 : WR;
                end
                WR: begin
                    if (!idx_ok) overflow <= 1'b1;
                    j <= last_col ? 8'd0 : j + 8'd1;
                    if (last_col && !last_row) i <= i + 8'd1;
                    state <= last_col && last_row ? DONE : RD0;
                end
                default: state <= IDLE;
            endcase
    pool_mem #(.DEPTH(ODEPTH), .AW(MAW)) u_mem (
        .clk(clk),
        .we(state == WR && idx_ok),
        .waddr(MAW'(idx)),
        .wdata(wr_val),
        .raddr(MAW'(po_addr)),
        .rdata(mem_rd)
    );
    assign po_data = 32'(po_addr) < ODEPTH ? mem_rd : '0;
endmodule

// File: tb/tb_conv_maxpool.sv
// tb_conv_maxpool: randomized scoreboard bench comparing conv_maxpool with a behavioural pooling model
module tb_conv_maxpool;
    localparam int DSIZE = 1024;
    localparam int ODEPTH = 16;
    localparam int ADDR_W = $clog2(DSIZE) + 1;
    localparam int AMAX = 1 << ADDR_W;

    logic clk = 0, rst_n = 0, start = 0;
    logic [7:0] in_width = 0, in_height = 0, row_pitch = 0;
    logic [ADDR_W-1:0] rd_addr, po_addr = 0;
    logic [31:0] rd_data, po_data;
    logic done, overflow;

    logic [31:0] cmem [AMAX];
    logic [31:0] pm [ODEPTH];
    bit pm_set [ODEPTH];
    bit allowed [AMAX];
    bit watch = 0;
    int bad_reads = 0;
    int cyc = 0;
    int checks = 0, errors = 0;
    int launched = 0, runs_done = 0;

    typedef struct { int id; int t0; int lat; bit ovf; int n_exp; int bad0; } run_t;
    typedef struct { int addr; logic [31:0] val; } exp_t;
    run_t runs[$];
    exp_t expq[$];

    conv_maxpool #(.DSIZE(DSIZE), .ODEPTH(ODEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_width(in_width), .in_height(in_height), .row_pitch(row_pitch),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .po_addr(po_addr), .po_data(po_data),
        .done(done), .overflow(overflow)
    );

    assign rd_data = cmem[rd_addr];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (watch && !allowed[rd_addr]) bad_reads++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pool_value(input logic [31:0] a, b, c, d);
        logic signed [31:0] m;
        m = $signed(a);
        if ($signed(b) > m) m = $signed(b);
        if ($signed(c) > m) m = $signed(c);
        if ($signed(d) > m) m = $signed(d);
`ifdef CONV_POOL_RELU_EN
        if (m < 0) m = 0;
`endif
        return m;
    endfunction

    // Reference: compute every window from the raster/address rules, then pulse start
    task automatic launch(input int w, input int h, input int p);
        int ow, oh, n, idx, cnt;
        int a [4];
        bit ovf;
        logic [31:0] m;
        run_t r;
        ow = w / 2; oh = h / 2; n = ow * oh; ovf = 0; cnt = 0;
        for (int k = 0; k < AMAX; k++) allowed[k] = (k == 0);
        for (int i = 0; i < oh; i++)
            for (int j = 0; j < ow; j++) begin
                for (int k = 0; k < 4; k++) begin
                    a[k] = ((2 * i + k / 2) * p + 2 * j + k % 2) % AMAX;
                    allowed[a[k]] = 1;
                end
                m = pool_value(cmem[a[0]], cmem[a[1]], cmem[a[2]], cmem[a[3]]);
                idx = i * ow + j;
                if (idx < ODEPTH) begin
                    expq.push_back('{idx, m});
                    pm[idx] = m;
                    pm_set[idx] = 1;
                    cnt++;
                end else ovf = 1;
            end
        @(negedge clk);
        in_width = 8'(w); in_height = 8'(h); row_pitch = 8'(p);
        watch = 1;
        start = 1;
        @(posedge clk);
        #1 start = 0;
        r = '{launched, cyc, n == 0 ? 1 : 5 * n + 1, ovf, cnt, bad_reads};
        launched++;
        runs.push_back(r);
    endtask

    task automatic finish_run();
        wait (runs_done == launched);
        watch = 0;
    endtask

    initial forever begin
        run_t r;
        exp_t e;
        bit seen;
        wait (runs.size() > 0);
        r = runs.pop_front();
        seen = 0;
        while (!seen && cyc - r.t0 <= r.lat + 10) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check($sformatf("run%0d done latency", r.id), seen ? cyc - r.t0 : -1, r.lat);
        check($sformatf("run%0d overflow", r.id), overflow, r.ovf);
        check($sformatf("run%0d stray rd_addr count", r.id), bad_reads - r.bad0, 0);
        for (int k = 0; k < r.n_exp; k++) begin
            e = expq.pop_front();
            po_addr = ADDR_W'(e.addr);
            #1 check($sformatf("run%0d window %0d", r.id, e.addr), po_data, e.val);
        end
        for (int k = 0; k < ODEPTH; k++)
            if (pm_set[k]) begin
                po_addr = ADDR_W'(k);
                #1 check($sformatf("run%0d mem word %0d", r.id, k), po_data, pm[k]);
            end
        runs_done++;
    end

    initial begin
        int w, h, p;
        logic [31:0] m0;
        for (int k = 0; k < AMAX; k++) cmem[k] = $urandom;
        repeat (3) @(negedge clk);
        check("reset done", done, 0);
        check("reset overflow", overflow, 0);
        check("reset rd_addr", rd_addr, 0);
        rst_n = 1;

        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) cmem[r * 8 + c] = 32'(4 * r + c);
        launch(4, 4, 8);
        finish_run();

        for (int r = 0; r < 3; r++) for (int c = 0; c < 5; c++) cmem[r * 6 + c] = 32'(10 * r + c);
        launch(5, 3, 6);
        finish_run();

        cmem[0] = -32'sd7; cmem[1] = -32'sd3; cmem[4] = -32'sd9; cmem[5] = -32'sd4;
        launch(2, 2, 4);
        finish_run();

        launch(1, 4, 4);
        finish_run();

        for (int k = 0; k < 64; k++) cmem[k] = $urandom;
        launch(4, 4, 8);
        repeat (6) @(posedge clk);
        @(negedge clk) start = 1;
        @(posedge clk) #1 start = 0;
        finish_run();

        for (int k = 0; k < 64; k++) cmem[k] = $urandom;
        m0 = pool_value(cmem[0], cmem[1], cmem[8], cmem[9]);
        @(negedge clk);
        in_width = 4; in_height = 4; row_pitch = 8; start = 1;
        @(posedge clk) #1 start = 0;
        repeat (7) @(posedge clk);
        #2 rst_n = 0;
        #1;
        check("async reset done", done, 0);
        check("async reset rd_addr", rd_addr, 0);
        pm[0] = m0; pm_set[0] = 1;
        @(negedge clk) rst_n = 1;
        launch(1, 6, 4);
        finish_run();

        for (int k = 0; k < 256; k++) cmem[k] = $urandom;
        launch(10, 10, 12);
        finish_run();

        for (int t = 0; t < 14; t++) begin
            for (int k = 0; k < 600; k++)
                cmem[k] = t[0] ? 32'($urandom_range(0, 7)) - 32'd4 : $urandom;
            w = $urandom_range(0, 20);
            h = $urandom_range(0, 20);
            p = w + $urandom_range(0, 8);
            launch(w, h, p);
            finish_run();
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
